// File: rtl/mips_pkg.sv
`timescale 1ns/1ps
// mips_pkg
// Shared definitions for the MIPS pipeline front end.
//   DEFAULT_RESET_PC  : PCF value after reset
//   DEFAULT_NOP_INSTR : encoding of sll $0,$0,0, used for pipeline bubbles
//   fetch_state_t     : fetch FSM states (FETCH, HOLD, SQUASH)
//   wordAlign()       : clears the byte-offset bits of an address
//   pcPlus4()         : 32-bit modulo PC increment
package mips_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        HOLD   = 2'd1,
        SQUASH = 2'd2
    } fetch_state_t;

    function automatic logic [31:0] wordAlign(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

    // Wraps naturally: 32'hFFFF_FFFC + 4 = 0.
    function automatic logic [31:0] pcPlus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
`timescale 1ns/1ps
// if_id_reg
// IF/ID pipeline register. Holds the instruction handed to decode together
// with its PC+4 and a valid bit that distinguishes real instructions from
// injected bubbles.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   stallD       : hold every field (wins over flushD)
//   flushD       : load a NOP bubble
//   instrValid   : an instruction is being delivered this cycle
//   instrIn      : delivered instruction
//   pcPlus4In    : PC+4 of the delivered instruction
//   instrD       : instruction to decode
//   pcPlus4D     : PC+4 of instrD
//   validD       : instrD is real (0 = bubble)
module if_id_reg
    import mips_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stallD,
    input  logic        flushD,
    input  logic        instrValid,
    input  logic [31:0] instrIn,
    input  logic [31:0] pcPlus4In,
    output logic [31:0] instrD,
    output logic [31:0] pcPlus4D,
    output logic        validD
);

    // Priority: stall > flush > deliver > bubble. A flush or a plain bubble
    // keeps pcPlus4D so decode still sees the last real PC+4.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instrD   <= NOP_INSTR;
            pcPlus4D <= 32'h0000_0000;
            validD   <= 1'b0;
        end else if (!stallD) begin
            if (flushD || !instrValid) begin
                instrD <= NOP_INSTR;
                validD <= 1'b0;
            end else begin
                instrD   <= instrIn;
                pcPlus4D <= pcPlus4In;
                validD   <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/fetch_stage.sv
`timescale 1ns/1ps
// fetch_stage
// IF stage of the 5-stage MIPS pipeline plus the IF/ID register. Keeps PCF,
// fetches from a variable-latency instruction memory with a req/ready
// handshake (one request outstanding), takes branch redirects from decode
// and honours the hazard unit's stall/flush controls.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   StallF               : hold PCF and fetch progress
//   StallD               : hold the IF/ID register
//   FlushD               : clear the IF/ID register to a bubble
//   PCSrcD, PCBranchD    : taken branch in decode and its target
//   ImemReq, ImemAddr    : fetch request and word-aligned address
//   ImemReady, ImemRdata : request completion and returned instruction
//   InstrD, PCPlus4D     : instruction to decode and its PC+4
//   ValidD               : InstrD is a real instruction (0 = bubble)
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        PCSrcD,
    input  logic [31:0] PCBranchD,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemReady,
    input  logic [31:0] ImemRdata,
    output logic [31:0] InstrD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
);

    fetch_state_t state, stateNext;
    logic [31:0]  pcF, pcFNext;
    logic [31:0]  instBuf, instBufNext;
    logic [31:0]  savedTarget, savedTargetNext;
    logic         reqFsm;
    logic         redirect;
    logic         deliver;
    logic [31:0]  deliverInstr;
    logic [31:0]  branchTarget;

    // A redirect while decode is stalled belongs to a branch that has not
    // really resolved yet, so it is ignored.
    assign redirect     = PCSrcD & ~StallD;
    assign branchTarget = wordAlign(PCBranchD);

    // Request is forced low during reset so the memory never sees a
    // request from an abandoned transaction.
    assign ImemReq  = reqFsm & rst_n;
    assign ImemAddr = pcF;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FETCH;
            pcF         <= RESET_PC;
            instBuf     <= NOP_INSTR;
            savedTarget <= RESET_PC;
        end else begin
            state       <= stateNext;
            pcF         <= pcFNext;
            instBuf     <= instBufNext;
            savedTarget <= savedTargetNext;
        end
    end

    // PCF only ever advances together with a delivered instruction, which
    // is what keeps fetch free of lost or duplicated instructions.
    always_comb begin
        stateNext       = state;
        pcFNext         = pcF;
        instBufNext     = instBuf;
        savedTargetNext = savedTarget;
        reqFsm          = 1'b0;
        deliver         = 1'b0;
        deliverInstr    = ImemRdata;

        case (state)
            FETCH: begin
                reqFsm = 1'b1;
                if (ImemReady) begin
                    if (redirect) begin
                        pcFNext = branchTarget;
                    end else if (!StallF) begin
                        deliver = 1'b1;
                        pcFNext = pcPlus4(pcF);
                    end else begin
                        instBufNext = ImemRdata;
                        stateNext   = HOLD;
                    end
                end else if (redirect) begin
                    // The memory still owes us this word; finish the
                    // transaction and throw its data away.
                    savedTargetNext = branchTarget;
                    stateNext       = SQUASH;
                end
            end

            HOLD: begin
                deliverInstr = instBuf;
                if (redirect) begin
                    pcFNext   = branchTarget;
                    stateNext = FETCH;
                end else if (!StallF) begin
                    deliver   = 1'b1;
                    pcFNext   = pcPlus4(pcF);
                    stateNext = FETCH;
                end
            end

            SQUASH: begin
                // Keep the old address on the bus until the memory completes.
                // A later redirect replaces the saved target, including one
                // arriving in the same cycle as ImemReady.
                reqFsm = 1'b1;
                if (redirect) begin
                    savedTargetNext = branchTarget;
                end
                if (ImemReady) begin
                    pcFNext   = savedTargetNext;
                    stateNext = FETCH;
                end
            end

            default: begin
                stateNext = FETCH;
            end
        endcase
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) ifIdReg (
        .clk        (clk),
        .rst_n      (rst_n),
        .stallD     (StallD),
        .flushD     (FlushD | redirect),
        .instrValid (deliver),
        .instrIn    (deliverInstr),
        .pcPlus4In  (pcPlus4(pcF)),
        .instrD     (InstrD),
        .pcPlus4D   (PCPlus4D),
        .validD     (ValidD)
    );

endmodule

// File: tb/tb_fetch_stage.sv
`timescale 1ns/1ps
// tb_fetch_stage
// Directed bench for fetch_stage. The instruction memory returns
// 32'h2400_0000 ^ address; ImemReady is driven cycle by cycle. Each test
// pushes the instructions it expects decode to receive into a scoreboard
// queue, and an independent monitor pops and compares whenever the IF/ID
// register presents a new valid instruction.
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        StallF;
    logic        StallD;
    logic        FlushD;
    logic        PCSrcD;
    logic [31:0] PCBranchD;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic        ImemReady;
    logic [31:0] ImemRdata;
    logic [31:0] InstrD;
    logic [31:0] PCPlus4D;
    logic        ValidD;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pcPlus4;
    } expect_t;

    expect_t sbQueue[$];
    int      checks = 0;
    int      errors = 0;
    logic    stallDSeen = 1'b0;

    fetch_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .StallF    (StallF),
        .StallD    (StallD),
        .FlushD    (FlushD),
        .PCSrcD    (PCSrcD),
        .PCBranchD (PCBranchD),
        .ImemReq   (ImemReq),
        .ImemAddr  (ImemAddr),
        .ImemReady (ImemReady),
        .ImemRdata (ImemRdata),
        .InstrD    (InstrD),
        .PCPlus4D  (PCPlus4D),
        .ValidD    (ValidD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign ImemRdata = 32'h2400_0000 ^ ImemAddr;

    always @(posedge clk) stallDSeen = StallD;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic pushExpect(input logic [31:0] instr, input logic [31:0] pcPlus4);
        expect_t e;
        e.instr   = instr;
        e.pcPlus4 = pcPlus4;
        sbQueue.push_back(e);
    endtask

    // Drive one cycle of inputs at a negedge and return at the next negedge.
    task automatic applyStimulus(input logic sF, input logic sD, input logic fD,
                                 input logic pS, input logic [31:0] pB,
                                 input logic rdy);
        StallF    = sF;
        StallD    = sD;
        FlushD    = fD;
        PCSrcD    = pS;
        PCBranchD = pB;
        ImemReady = rdy;
        @(negedge clk);
    endtask

    // Scoreboard monitor: an instruction is presented when ValidD is high
    // and the register was loaded (not stalled) at the preceding edge.
    always @(negedge clk) begin
        if (rst_n && ValidD && !stallDSeen) begin
            if (sbQueue.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpectedInstr: got %h pc4 %h expected none",
                         InstrD, PCPlus4D);
            end else begin
                expect_t e;
                e = sbQueue.pop_front();
                checkOutput("sbInstrD", InstrD, e.instr);
                checkOutput("sbPCPlus4D", PCPlus4D, e.pcPlus4);
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        StallF    = 1'b0;
        StallD    = 1'b0;
        FlushD    = 1'b0;
        PCSrcD    = 1'b0;
        PCBranchD = 32'h0;
        ImemReady = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("rstImemReq", {31'b0, ImemReq}, 32'd0);
        checkOutput("rstValidD", {31'b0, ValidD}, 32'd0);
        checkOutput("rstInstrD", InstrD, 32'h0000_0000);
        checkOutput("rstPCPlus4D", PCPlus4D, 32'h0000_0000);
        checkOutput("rstImemAddr", ImemAddr, 32'h0000_0000);

        rst_n = 1'b1;
        #1;
        checkOutput("relImemReq", {31'b0, ImemReq}, 32'd1);
        @(negedge clk);

        // Test 1: zero-wait memory, four back-to-back instructions.
        pushExpect(32'h2400_0000, 32'h04);
        pushExpect(32'h2400_0004, 32'h08);
        pushExpect(32'h2400_0008, 32'h0C);
        pushExpect(32'h2400_000C, 32'h10);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 32'h0, 1);
        applyStimulus(0, 0, 0, 0, 32'h0, 0);
        checkOutput("t1Bubble", {31'b0, ValidD}, 32'd0);
        checkOutput("t1Addr", ImemAddr, 32'h10);

        // Test 2: ImemReady three cycles late.
        pushExpect(32'h2400_0010, 32'h14);
        for (int i = 0; i < 3; i++) begin
            checkOutput("t2AddrStable", ImemAddr, 32'h10);
            checkOutput("t2Req", {31'b0, ImemReq}, 32'd1);
            applyStimulus(0, 0, 0, 0, 32'h0, 0);
            checkOutput("t2Bubble", {31'b0, ValidD}, 32'd0);
        end
        checkOutput("t2AddrStable", ImemAddr, 32'h10);
        applyStimulus(0, 0, 0, 0, 32'h0, 1);
        checkOutput("t2Addr", ImemAddr, 32'h14);

        // Test 3: fetch completes under StallF/StallD, held in HOLD.
        applyStimulus(1, 1, 0, 0, 32'h0, 1);
        checkOutput("t3HoldReq", {31'b0, ImemReq}, 32'd0);
        applyStimulus(1, 1, 0, 0, 32'h0, 0);
        checkOutput("t3HoldReq2", {31'b0, ImemReq}, 32'd0);
        pushExpect(32'h2400_0014, 32'h18);
        applyStimulus(0, 0, 0, 0, 32'h0, 0);
        applyStimulus(0, 0, 0, 0, 32'h0, 0);
        checkOutput("t3PcOnce", ImemAddr, 32'h18);
        checkOutput("t3NoDup", {31'b0, ValidD}, 32'd0);

        // Test 4: redirect while a fetch completes.
        pushExpect(32'h2400_0018, 32'h1C);
        applyStimulus(0, 0, 0, 0, 32'h0, 1);
        applyStimulus(0, 0, 0, 1, 32'h40, 1);
        checkOutput("t4FlushInstr", InstrD, 32'h0000_0000);
        checkOutput("t4FlushValid", {31'b0, ValidD}, 32'd0);
        checkOutput("t4Addr", ImemAddr, 32'h40);
        pushExpect(32'h2400_0040, 32'h44);
        applyStimulus(0, 0, 0, 0, 32'h0, 1);

        // Test 5: redirect during a pending fetch goes through SQUASH.
        applyStimulus(0, 0, 0, 0, 32'h0, 0);
        applyStimulus(0, 0, 0, 1, 32'h80, 0);
        checkOutput("t5SquashReq", {31'b0, ImemReq}, 32'd1);
        checkOutput("t5OldAddr", ImemAddr, 32'h44);
        applyStimulus(0, 0, 0, 0, 32'h0, 0);
        checkOutput("t5OldAddr2", ImemAddr, 32'h44);
        applyStimulus(0, 0, 0, 0, 32'h0, 1);
        checkOutput("t5NoStale", {31'b0, ValidD}, 32'd0);
        checkOutput("t5Addr", ImemAddr, 32'h80);
        pushExpect(32'h2400_0080, 32'h84);
        applyStimulus(0, 0, 0, 0, 32'h0, 1);

        // Boundary: unaligned target is aligned, PC+4 wraps to zero.
        applyStimulus(0, 0, 0, 1, 32'hFFFF_FFFF, 1);
        checkOutput("wrapAddr", ImemAddr, 32'hFFFF_FFFC);
        pushExpect(32'hDBFF_FFFC, 32'h0000_0000);
        applyStimulus(0, 0, 0, 0, 32'h0, 1);
        checkOutput("wrapNext", ImemAddr, 32'h0000_0000);

        // StallD has priority over FlushD; FlushD alone makes a bubble.
        pushExpect(32'h2400_0000, 32'h04);
        applyStimulus(0, 0, 0, 0, 32'h0, 1);
        applyStimulus(1, 1, 1, 0, 32'h0, 0);
        checkOutput("stallWinsInstr", InstrD, 32'h2400_0000);
        checkOutput("stallWinsValid", {31'b0, ValidD}, 32'd1);
        applyStimulus(0, 0, 1, 0, 32'h0, 0);
        checkOutput("flushInstr", InstrD, 32'h0000_0000);
        checkOutput("flushValid", {31'b0, ValidD}, 32'd0);

        // Test 6: reset in the middle of a request.
        pushExpect(32'h2400_0004, 32'h08);
        applyStimulus(0, 0, 0, 0, 32'h0, 1);
        ImemReady = 1'b0;
        #2;
        checkOutput("t6PreReq", {31'b0, ImemReq}, 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("t6RstReq", {31'b0, ImemReq}, 32'd0);
        checkOutput("t6RstValid", {31'b0, ValidD}, 32'd0);
        checkOutput("t6RstPc4", PCPlus4D, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("t6RelReq", {31'b0, ImemReq}, 32'd1);
        checkOutput("t6RelAddr", ImemAddr, 32'h0000_0000);
        pushExpect(32'h2400_0000, 32'h04);
        applyStimulus(0, 0, 0, 0, 32'h0, 1);
        repeat (2) applyStimulus(0, 0, 0, 0, 32'h0, 0);

        checkOutput("sbDrained", sbQueue.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
